// File: rtl/load_store_unit.sv
// 32-bit RISC-V load/store unit: aligned loads with sign/zero extension, word stores in one
// cycle, and byte/half stores as a two-cycle read-modify-write. Misaligned accesses raise a sticky fault.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic [31:0] bad_addr,
  input  logic        clr_fault,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {StIdle, StMerge} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_merge, w_merge_next;
  logic [31:0] r_word_addr;
  logic [31:0] r_bad_addr;
  logic        r_fault;

  logic        w_is_b, w_is_h, w_is_w, w_legal, w_misalign;
  logic        w_req, w_ok, w_fault_evt, w_sign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load, w_merged;

  assign w_is_b = (funct3[1:0] == 2'b00);
  assign w_is_h = (funct3[1:0] == 2'b01);
  assign w_is_w = (funct3 == 3'b010);
  assign w_sign = ~funct3[2];

  // Stores have no unsigned variants, so funct3[2] must be clear for them.
  assign w_legal = req_we ? (~funct3[2] && funct3[1:0] != 2'b11)
                          : (funct3[1:0] != 2'b11 && funct3 != 3'b110);

  assign w_misalign  = (w_is_h & addr[0]) | (w_is_w & (addr[1:0] != 2'b00));
  assign w_req       = req_valid & w_legal & (r_state == StIdle) & ~rst;
  assign w_fault_evt = w_req & w_misalign;
  assign w_ok        = w_req & ~w_misalign;

  assign w_byte = mem_rdata[{addr[1:0], 3'b000} +: 8];
  assign w_half = mem_rdata[{addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load = mem_rdata;
    if (w_is_b) begin
      w_load = {{24{w_sign & w_byte[7]}}, w_byte};
    end else if (w_is_h) begin
      w_load = {{16{w_sign & w_half[15]}}, w_half};
    end
  end

  always_comb begin
    w_merged = mem_rdata;
    if (w_is_b) begin
      w_merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
    end else begin
      w_merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_merge_next = r_merge;
    rdata        = 32'h0;
    stall        = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = {addr[31:2], 2'b00};
    mem_wdata    = wdata;
    unique case (r_state)
      StIdle: begin
        if (w_ok) begin
          if (!req_we) begin
            rdata = w_load;
          end else if (w_is_w) begin
            mem_write = 1'b1;
          end else begin
            stall        = 1'b1;
            w_merge_next = w_merged;
            w_state_next = StMerge;
          end
        end
      end
      StMerge: begin
        mem_addr     = r_word_addr;
        mem_wdata    = r_merge;
        // A reset landing on the merge cycle cancels the pending write.
        mem_write    = ~rst;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_merge     <= 32'h0;
      r_word_addr <= 32'h0;
      r_fault     <= 1'b0;
      r_bad_addr  <= 32'h0;
    end else begin
      r_state <= w_state_next;
      r_merge <= w_merge_next;
      if (w_ok && req_we && !w_is_w) begin
        r_word_addr <= {addr[31:2], 2'b00};
      end
      // A clear coinciding with a new fault lets the new address through.
      if (w_fault_evt) begin
        r_fault <= 1'b1;
        if (!r_fault || clr_fault) begin
          r_bad_addr <= addr;
        end
      end else if (clr_fault) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign fault    = r_fault;
  assign bad_addr = r_bad_addr;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a word-addressed memory model and
// scoreboard queues for expected load results and expected memory writes.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, clr_fault;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata, bad_addr, mem_addr, mem_wdata, mem_rdata;
  logic        stall, fault, mem_write;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];
  logic        pl_we = 1'b0;
  logic [7:0]  pl_idx = 8'h0;
  logic [31:0] pl_data = 32'h0;

  logic [31:0] exp_rd_q [$];
  logic [63:0] exp_wr_q [$];

  load_store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .fault     (fault),
    .bad_addr  (bad_addr),
    .clr_fault (clr_fault),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_write === 1'b1) mem[mem_addr[9:2]] <= mem_wdata;
    else if (pl_we) mem[pl_idx] <= pl_data;
  end

  // Every memory write must match the next expected write in order.
  always @(negedge clk) begin : wr_monitor
    logic [63:0] e;
    if (mem_write === 1'b1) begin
      total++;
      if (exp_wr_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%h data=%h required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_wr_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          bad++;
          $display("FAIL mem_write_word got addr=%h data=%h required addr=%h data=%h",
                   mem_addr, mem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    funct3    = f;
    addr      = a;
    wdata     = d;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    pl_we   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    next_cycle();
    pl_we = 1'b0;
  endtask

  // Drives a load, pushes its expected result, and compares when the output settles.
  task automatic do_load(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] exp);
    logic [31:0] e;
    drive(1'b1, 1'b0, f, a, 32'h0);
    exp_rd_q.push_back(exp);
    @(negedge clk);
    e = exp_rd_q.pop_front();
    total++;
    if (rdata !== e || stall !== 1'b0 || mem_write !== 1'b0) begin
      bad++;
      $display("FAIL %s got rdata=%h stall=%b mem_write=%b required rdata=%h stall=0 mem_write=0",
               name, rdata, stall, mem_write, e);
    end
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 3'b010, 32'h8, 32'h55);
    @(negedge clk);
    total++;
    if (mem_write !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got mem_write=%b stall=%b required 0 0", mem_write, stall);
    end
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (fault !== 1'b0 || bad_addr !== 32'h0 || stall !== 1'b0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_state got fault=%b bad_addr=%h stall=%b rdata=%h required 0 0 0 0",
               fault, bad_addr, stall, rdata);
    end
    next_cycle();
  endtask

  task automatic test_idle_illegal();
    preload(8'h00, 32'hCAFEF00D);
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (rdata !== 32'h0 || mem_write !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL idle got rdata=%h mem_write=%b stall=%b required 0 0 0",
               rdata, mem_write, stall);
    end
    next_cycle();
    drive(1'b1, 1'b0, 3'b011, 32'h1, 32'h0);
    @(negedge clk);
    total++;
    if (rdata !== 32'h0 || mem_write !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL illegal_load got rdata=%h mem_write=%b stall=%b required 0 0 0",
               rdata, mem_write, stall);
    end
    next_cycle();
    drive(1'b1, 1'b1, 3'b101, 32'h2, 32'h1234);
    @(negedge clk);
    total++;
    if (fault !== 1'b0 || mem_write !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL illegal_store got fault=%b mem_write=%b stall=%b required 0 0 0",
               fault, mem_write, stall);
    end
    next_cycle();
  endtask

  task automatic test_sign_ext();
    logic [2:0]  f [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b000, 3'b001, 3'b010};
    logic [31:0] a [8] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101, 32'h100,
                           32'h100};
    logic [31:0] x [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h00000001,
                           32'h0000007F, 32'h00007F01, 32'h80FF7F01};
    preload(8'h40, 32'h80FF7F01);
    for (int i = 0; i < 8; i++) do_load($sformatf("load_ext_%0d", i), f[i], a[i], x[i]);
  endtask

  task automatic sub_store(input string name, input logic [31:0] a, input logic [2:0] f,
                           input logic [31:0] d, input logic [31:0] exp_word);
    drive(1'b1, 1'b1, f, a, d);
    exp_wr_q.push_back({a[31:2], 2'b00, exp_word});
    @(negedge clk);
    total++;
    if (stall !== 1'b1 || mem_write !== 1'b0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL %s_cycle_a got stall=%b mem_write=%b rdata=%h required 1 0 0",
               name, stall, mem_write, rdata);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (stall !== 1'b0 || mem_write !== 1'b1) begin
      bad++;
      $display("FAIL %s_cycle_b got stall=%b mem_write=%b required 0 1", name, stall, mem_write);
    end
    next_cycle();
  endtask

  task automatic test_byte_store();
    preload(8'h10, 32'h11223344);
    sub_store("sb_rmw", 32'h41, 3'b000, 32'hFFFFFFAB, 32'h1122AB44);
    do_load("reload_sb", 3'b010, 32'h40, 32'h1122AB44);
    sub_store("sh_rmw", 32'h42, 3'b001, 32'hFFFF5566, 32'h5566AB44);
    do_load("reload_sh", 3'b010, 32'h40, 32'h5566AB44);
  endtask

  task automatic test_word_store();
    drive(1'b1, 1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
    exp_wr_q.push_back({32'h8, 32'hDEADBEEF});
    @(negedge clk);
    total++;
    if (mem_write !== 1'b1 || stall !== 1'b0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL sw got mem_write=%b stall=%b rdata=%h required 1 0 0",
               mem_write, stall, rdata);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 3'b010, 32'h50, 32'hA5A5A5A5);
    exp_wr_q.push_back({32'h50, 32'hA5A5A5A5});
    @(negedge clk);
    next_cycle();
    sub_store("b2b_sb", 32'h53, 3'b000, 32'h0000003C, 32'h3CA5A5A5);
    do_load("b2b_lbu", 3'b100, 32'h53, 32'h0000003C);
    do_load("b2b_lw", 3'b010, 32'h50, 32'h3CA5A5A5);
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b0, 3'b010, 32'h6, 32'h0);
    @(negedge clk);
    total++;
    if (rdata !== 32'h0 || mem_write !== 1'b0 || stall !== 1'b0 || fault !== 1'b0) begin
      bad++;
      $display("FAIL misalign_lw got rdata=%h mem_write=%b stall=%b fault=%b required 0 0 0 0",
               rdata, mem_write, stall, fault);
    end
    next_cycle();
    drive(1'b1, 1'b1, 3'b001, 32'h9, 32'h1);
    @(negedge clk);
    total++;
    if (fault !== 1'b1 || bad_addr !== 32'h6 || mem_write !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL fault_set got fault=%b bad_addr=%h mem_write=%b stall=%b required 1 6 0 0",
               fault, bad_addr, mem_write, stall);
    end
    next_cycle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (fault !== 1'b1 || bad_addr !== 32'h6) begin
      bad++;
      $display("FAIL bad_addr_sticky got fault=%b bad_addr=%h required 1 6", fault, bad_addr);
    end
    next_cycle();
    clr_fault = 1'b1;
    next_cycle();
    clr_fault = 1'b0;
    @(negedge clk);
    total++;
    if (fault !== 1'b0) begin
      bad++;
      $display("FAIL clr_fault got fault=%b required 0", fault);
    end
    next_cycle();
  endtask

  task automatic test_clr_and_fault();
    drive(1'b1, 1'b0, 3'b010, 32'h6, 32'h0);
    next_cycle();
    clr_fault = 1'b1;
    drive(1'b1, 1'b0, 3'b001, 32'h3, 32'h0);
    @(negedge clk);
    total++;
    if (fault !== 1'b1 || bad_addr !== 32'h6) begin
      bad++;
      $display("FAIL pre_clr_fault got fault=%b bad_addr=%h required 1 6", fault, bad_addr);
    end
    next_cycle();
    clr_fault = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (fault !== 1'b1 || bad_addr !== 32'h3) begin
      bad++;
      $display("FAIL clr_and_fault got fault=%b bad_addr=%h required 1 3", fault, bad_addr);
    end
    next_cycle();
  endtask

  task automatic test_reset_merge();
    preload(8'h08, 32'h12345678);
    drive(1'b1, 1'b1, 3'b001, 32'h20, 32'h0000BEEF);
    @(negedge clk);
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL rst_merge_cycle_a got stall=%b required 1", stall);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (mem_write !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL rst_in_merge got mem_write=%b stall=%b required 0 0", mem_write, stall);
    end
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (stall !== 1'b0 || fault !== 1'b0 || bad_addr !== 32'h0 || mem[8] !== 32'h12345678) begin
      bad++;
      $display("FAIL rst_merge_after got stall=%b fault=%b bad_addr=%h word=%h required 0 0 0 12345678",
               stall, fault, bad_addr, mem[8]);
    end
    next_cycle();
    do_load("rst_reload", 3'b010, 32'h20, 32'h12345678);
    sub_store("post_rst_sb", 32'h20, 3'b000, 32'h00000099, 32'h12345699);
  endtask

  initial begin
    rst       = 1'b1;
    clr_fault = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    test_reset();
    test_idle_illegal();
    test_sign_ext();
    test_byte_store();
    test_word_store();
    test_back_to_back();
    test_misaligned();
    test_clr_and_fault();
    test_reset_merge();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) next_cycle();
    total++;
    if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
      bad++;
      $display("FAIL queues_drained got wr=%0d rd=%0d pending required 0 0",
               exp_wr_q.size(), exp_rd_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters; the data path is fixed at 32 bits.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst as in the rest of the codebase.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  core memory request present this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 funct3  in  3  RISC-V width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 addr  in  32  byte address from the ALU.
REQ-009 wdata  in  32  store data from rs2 (low lanes used for B/H).
REQ-010 rdata  out  32  aligned, extended load result to writeback.
REQ-011 stall  out  1  core shall hold PC and all request inputs stable while high.
REQ-012 fault  out  1  sticky misaligned-access flag.
REQ-013 bad_addr  out  32  address of the first faulting access.
REQ-014 clr_fault  in  1  clears fault.
REQ-015 mem_addr  out  32  word address to data memory, {addr[31:2],2'b00}.
REQ-016 mem_write  out  1  data memory write enable.
REQ-017 mem_wdata  out  32  data memory write word.
REQ-018 mem_rdata  in  32  data memory read word, combinational on mem_addr.

Function
REQ-019 The FSM SHALL have two states, IDLE and MERGE; IDLE -> MERGE only on an aligned SB/SH in IDLE; MERGE -> IDLE unconditionally after one cycle.
REQ-020 Misalignment SHALL be defined as: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0; byte accesses are never misaligned.
REQ-021 Idle (req_valid=0) or illegal funct3 SHALL drive mem_write=0, rdata=0, stall=0, with no fault raised.
REQ-022 An aligned load in IDLE SHALL complete combinationally in the same cycle with stall=0: byte lane addr[1:0], half lane addr[1], sign-extended for B/H and zero-extended for BU/HU.
REQ-023 An aligned SW in IDLE SHALL drive mem_write=1 and mem_wdata=wdata in the same cycle, with stall=0.
REQ-024 An aligned SB/SH in IDLE (cycle A) SHALL drive mem_write=0 and stall=1, and SHALL capture mem_rdata, with the addressed lane replaced by wdata[7:0] or wdata[15:0], into merge_reg; the word address SHALL be latched.
REQ-025 In MERGE (cycle B) the block SHALL drive mem_addr=latched address, mem_write=1, mem_wdata=merge_reg and stall=0, and SHALL ignore all request inputs.
REQ-026 A misaligned access SHALL drive mem_write=0, rdata=0 and stall=0; fault SHALL be set on the next edge.
REQ-027 bad_addr SHALL capture addr only when fault is currently 0; later faults SHALL not overwrite it.
REQ-028 clr_fault SHALL clear fault on the next edge; clr_fault and a new fault in the same cycle SHALL leave fault=1 and capture the new address.
REQ-029 rdata SHALL be 0 during any store, and mem_write SHALL never be asserted for a load.

Reset
REQ-030 While rst=1 the block SHALL drive mem_write=0 and stall=0, and on the edge SHALL set state=IDLE, fault=0, bad_addr=0 and merge_reg=0.
REQ-031 Reset asserted during MERGE SHALL drop the pending write; no memory write SHALL occur in that cycle.

Verification
REQ-032 Sign extension: mem_rdata=0x80FF7F01, LB addr=0x103 -> rdata=0xFFFFFF80; LBU -> 0x00000080; LH addr=0x102 -> 0xFFFF80FF; LHU -> 0x000080FF; all with stall=0.
REQ-033 Byte store RMW: word at 0x40=0x11223344, SB addr=0x41, wdata=0xAB -> cycle A stall=1, mem_write=0; cycle B mem_write=1, mem_wdata=0x1122AB44; a reload of 0x40 returns 0x1122AB44.
REQ-034 Word store: SW addr=0x8, wdata=0xDEADBEEF -> same-cycle mem_write=1, mem_wdata=0xDEADBEEF, stall=0.
REQ-035 Misaligned: LW addr=0x6 -> rdata=0, mem_write=0, next cycle fault=1, bad_addr=0x6; then SH addr=0x9 -> bad_addr stays 0x6; clr_fault with no new fault -> fault=0.
REQ-036 Simultaneous clear and fault: fault=1 with clr_fault=1 and LH addr=0x3 in the same cycle -> fault=1, bad_addr=0x3.
REQ-037 Reset mid-operation: SH addr=0x20, assert rst in the MERGE cycle -> no write to 0x20, state=IDLE, stall=0, fault=0.
